// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over 8N1 UART, writes the instruction RAM,
// holds the CPU in reset until the checksum verifies. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 2048
`ifdef LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 27_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  input  logic [10:0] adr,
  output logic [15:0] dout,
  output logic        cpu_rst_n,
  output logic        loading,
  output logic        load_done,
  output logic        err,
  output logic [11:0] word_cnt
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {L_SYNC, L_CNT_H, L_CNT_L, L_DATA_LO, L_DATA_HI, L_SUM} ld_state_e;

  logic [15:0] mem [DEPTH];

  logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  ld_state_e       ld_state_q, ld_state_d;
  logic [11:0]     n_q, n_d, n_new;
  logic [7:0]      lo_q, lo_d, sum_q, sum_d;
  logic [11:0]     word_cnt_q, word_cnt_d;
  logic            cpu_rst_n_q, cpu_rst_n_d, loading_q, loading_d;
  logic            load_done_q, load_done_d, err_q, err_d;
  logic            wr_en_q, wr_en_d;
  logic [10:0]     wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d, dout_q, dout_d;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    rx_s1_d    = uart_rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      default: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_valid_d = rx_s2_q;
        rx_ferr_d  = !rx_s2_q;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Loader acts on the registered rx pulse; rx_shift_q is stable for that cycle.
  always_comb begin
    ld_state_d  = ld_state_q;
    n_d         = n_q;
    n_new       = {n_q[11:8], rx_shift_q};
    lo_d        = lo_q;
    sum_d       = sum_q;
    word_cnt_d  = word_cnt_q;
    cpu_rst_n_d = cpu_rst_n_q;
    loading_d   = loading_q;
    load_done_d = load_done_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
`ifdef LOADER_TIMEOUT_EN
    to_cnt_d = (ld_state_q == L_SYNC || rx_valid_q) ? '0 : to_cnt_q + 1'b1;
`endif
    if (rx_ferr_q) begin
      err_d      = 1'b1;
      loading_d  = 1'b0;
      ld_state_d = L_SYNC;
    end else if (rx_valid_q) begin
      case (ld_state_q)
        L_SYNC: if (rx_shift_q == 8'h55) begin
          cpu_rst_n_d = 1'b0;
          loading_d   = 1'b1;
          load_done_d = 1'b0;
          err_d       = 1'b0;
          word_cnt_d  = '0;
          sum_d       = '0;
          ld_state_d  = L_CNT_H;
        end
        L_CNT_H: begin
          n_d        = {rx_shift_q[3:0], n_q[7:0]};
          ld_state_d = L_CNT_L;
        end
        L_CNT_L: begin
          n_d = n_new;
          if (n_new == '0 || n_new > 12'(DEPTH)) begin
            err_d      = 1'b1;
            loading_d  = 1'b0;
            ld_state_d = L_SYNC;
          end else begin
            ld_state_d = L_DATA_LO;
          end
        end
        L_DATA_LO: begin
          lo_d       = rx_shift_q;
          sum_d      = sum_q + rx_shift_q;
          ld_state_d = L_DATA_HI;
        end
        L_DATA_HI: begin
          sum_d      = sum_q + rx_shift_q;
          wr_en_d    = 1'b1;
          wr_addr_d  = word_cnt_q[10:0];
          wr_data_d  = {rx_shift_q, lo_q};
          word_cnt_d = word_cnt_q + 12'd1;
          ld_state_d = (word_cnt_d == n_q) ? L_SUM : L_DATA_LO;
        end
        default: begin
          if (rx_shift_q == sum_q) begin
            load_done_d = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          loading_d  = 1'b0;
          ld_state_d = L_SYNC;
        end
      endcase
`ifdef LOADER_TIMEOUT_EN
    end else if (ld_state_q != L_SYNC && to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
      err_d      = 1'b1;
      loading_d  = 1'b0;
      ld_state_d = L_SYNC;
`endif
    end
  end

  always_comb dout_d = mem[adr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
      ld_state_q  <= L_SYNC;
      n_q         <= '0;
      lo_q        <= '0;
      sum_q       <= '0;
      word_cnt_q  <= '0;
      cpu_rst_n_q <= 1'b1;
      loading_q   <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dout_q      <= '0;
`ifdef LOADER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_ferr_q   <= rx_ferr_d;
      ld_state_q  <= ld_state_d;
      n_q         <= n_d;
      lo_q        <= lo_d;
      sum_q       <= sum_d;
      word_cnt_q  <= word_cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      loading_q   <= loading_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      dout_q      <= dout_d;
`ifdef LOADER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // NOTE: the RAM array has no reset; a mid-frame reset must leave already-written words intact.
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
  end

  assign dout      = dout_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign loading   = loading_q;
  assign load_done = load_done_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scenario bench for prog_loader at DIV=10; memory contents checked through a scoreboard queue.
module tb_prog_loader;

  localparam int DIV = 10;

  typedef logic [7:0] bytes_t [$];
  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [10:0] adr = '0;
  logic [15:0] dout;
  logic        cpu_rst_n, loading, load_done, err;
  logic [11:0] word_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  prog_loader #(
    .CLK_HZ(1_000_000),
    .BAUD  (100_000),
    .DEPTH (2048)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT_CYC(500)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .adr      (adr),
    .dout     (dout),
    .cpu_rst_n(cpu_rst_n),
    .loading  (loading),
    .load_done(load_done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(posedge clk) uart_rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    uart_rx = stop_ok;
    repeat (DIV) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
  endtask

  task automatic send_frame(input bytes_t f);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  // Model: a complete frame fills words 0..N-1 with {hi,lo}.
  task automatic push_frame(input bytes_t f);
    int n;
    exp_t e;
    n = {f[1][3:0], f[2]};
    for (int i = 0; i < n; i++) begin
      e.a = 11'(i);
      e.d = {f[4 + 2 * i], f[3 + 2 * i]};
      exp_q.push_back(e);
    end
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_crst, input logic e_load, input logic [11:0] e_wc);
    @(negedge clk);
    n_checks++;
    if (load_done !== e_done) begin
      n_fail++;
      $display("FAIL %s load_done: got %b want %b", tag, load_done, e_done);
    end
    n_checks++;
    if (err !== e_err) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b", tag, err, e_err);
    end
    n_checks++;
    if (cpu_rst_n !== e_crst) begin
      n_fail++;
      $display("FAIL %s cpu_rst_n: got %b want %b", tag, cpu_rst_n, e_crst);
    end
    n_checks++;
    if (loading !== e_load) begin
      n_fail++;
      $display("FAIL %s loading: got %b want %b", tag, loading, e_load);
    end
    n_checks++;
    if (word_cnt !== e_wc) begin
      n_fail++;
      $display("FAIL %s word_cnt: got %0d want %0d", tag, word_cnt, e_wc);
    end
  endtask

  task automatic drain_scoreboard(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk) adr = e.a;
      @(negedge clk);
      n_checks++;
      if (dout !== e.d) begin
        n_fail++;
        $display("FAIL %s dout[%0d]: got %h want %h", tag, e.a, dout, e.d);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    n_checks++;
    if (dout !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset dout: got %h want 0000", dout);
    end
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_valid_load();
    bytes_t fr = {8'h55, 8'h00, 8'h02, 8'hA0, 8'h80, 8'h08, 8'h00, 8'h28};
    push_frame(fr);
    send_byte(fr[0], 1'b1);
    check_status("valid_after_sync", 1'b0, 1'b0, 1'b0, 1'b1, 12'd0);
    for (int i = 1; i < fr.size(); i++) send_byte(fr[i], 1'b1);
    check_status("valid_done", 1'b1, 1'b0, 1'b1, 1'b0, 12'd2);
    drain_scoreboard("valid");
  endtask

  task automatic test_bad_checksum();
    bytes_t bad = {8'h55, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h29};
    bytes_t good = {8'h55, 8'h00, 8'h02, 8'hA0, 8'h80, 8'h08, 8'h00, 8'h28};
    push_frame(bad);
    send_frame(bad);
    check_status("bad_sum", 1'b0, 1'b1, 1'b0, 1'b0, 12'd2);
    drain_scoreboard("bad_sum");
    push_frame(good);
    send_frame(good);
    check_status("bad_sum_resend", 1'b1, 1'b0, 1'b1, 1'b0, 12'd2);
    drain_scoreboard("bad_sum_resend");
  endtask

  task automatic test_bad_count();
    bytes_t fr = {8'h55, 8'h08, 8'h01};
    send_frame(fr);
    check_status("bad_count", 1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
  endtask

  task automatic test_framing_error();
    bytes_t pre = {8'h55, 8'h00, 8'h02, 8'hA0};
    bytes_t nxt = {8'h55, 8'h00, 8'h01, 8'h34, 8'h12, 8'h46};
    exp_t e;
    send_frame(pre);
    send_byte(8'h80, 1'b0);
    check_status("framing", 1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
    push_frame(nxt);
    e.a = 11'd1;
    e.d = 16'h0008;
    exp_q.push_back(e);
    send_frame(nxt);
    check_status("framing_next", 1'b1, 1'b0, 1'b1, 1'b0, 12'd1);
    drain_scoreboard("framing_next");
  endtask

  task automatic test_reset_mid_frame();
    bytes_t pre = {8'h55, 8'h00, 8'h02, 8'hA0};
    send_frame(pre);
    @(negedge clk) rst_n = 1'b0;
    check_status("reset_mid", 1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bytes_t fr = {8'h55, 8'h00, 8'h01};
    send_frame(fr);
    repeat (600) @(posedge clk);
    check_status("timeout", 1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_valid_load();
    test_bad_checksum();
    test_bad_count();
    test_framing_error();
    test_reset_mid_frame();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
